// File: rtl/exec_muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide execute stage.
package exec_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIVU = 2'b10,
        MD_REMU = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/exec_muldiv_unit_core.sv
// Shift registers for shift-add multiply and restoring divide; one step per enable.
module muldiv_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    // hi: product high half / partial remainder; lo: multiplier / dividend-then-quotient
    logic [W-1:0] hi_q, lo_q, b_q;
    logic [W:0]   sum, trial;

    always_comb begin
        sum   = {1'b0, hi_q} + {1'b0, b_q};
        // Remainder stays below the divisor, so W+1 bits cannot lose the borrow.
        trial = {hi_q, lo_q[W-1]} - {1'b0, b_q};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load_i) begin
            hi_q <= '0;
            lo_q <= a_i;
            b_q  <= b_i;
        end else if (step_i) begin
            if (div_i) begin
                if (!trial[W]) begin
                    hi_q <= trial[W-1:0];
                    lo_q <= {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_q <= {hi_q[W-2:0], lo_q[W-1]};
                    lo_q <= {lo_q[W-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_q, lo_q} <= {sum, lo_q[W-1:1]};
            end else begin
                {hi_q, lo_q} <= {1'b0, hi_q, lo_q[W-1:1]};
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative MUL/MULH/DIVU/REMU stage feeding the register-file write port.
module exec_muldiv_unit
    import exec_muldiv_unit_pkg::*;
#(
    parameter int index_width = 3,
    parameter int reg_width   = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [index_width-1:0] rd,
    input  logic [reg_width-1:0]   S1,
    input  logic [reg_width-1:0]   S2,
    output logic                   busy,
    output logic                   done,
    output logic                   we,
    output logic [index_width-1:0] op0,
    output logic [reg_width-1:0]   D
);

    localparam int CW = $clog2(reg_width + 1);

    md_state_e              state_q;
    md_op_e                 op_q;
    logic [CW-1:0]          cnt_q;
    logic [index_width-1:0] rd_q, op0_q;
    logic [reg_width-1:0]   D_q, result;
    logic                   dz_q, done_q;
    logic                   launch, step, s2_zero;
    logic [reg_width-1:0]   hi, lo;

    assign s2_zero = (S2 == '0);
    assign launch  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign step    = (state_q == ST_MUL) || (state_q == ST_DIV);

    muldiv_iter_core #(.W(reg_width)) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (launch),
        .step_i (step),
        .div_i  (state_q == ST_DIV),
        .a_i    (S1),
        .b_i    (S2),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    // On divide-by-zero no step ran, so lo still holds the dividend.
    always_comb begin
        result = lo;
        case (op_q)
            MD_MUL:  result = lo;
            MD_MULH: result = hi;
            MD_DIVU: result = dz_q ? '1 : lo;
            MD_REMU: result = dz_q ? lo : hi;
            default: result = lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            rd_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            op0_q   <= '0;
            D_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_MUL, ST_DIV: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    D_q     <= result;
                    op0_q   <= rd_q;
                    state_q <= ST_IDLE;
                end
                default: ;
            endcase
            // A launch from DONE overrides the return to IDLE; the write above uses the old rd_q.
            if (launch) begin
                op_q  <= md_op_e'(op);
                rd_q  <= rd;
                cnt_q <= CW'(reg_width);
                dz_q  <= op[1] && s2_zero;
                if (!op[1])       state_q <= ST_MUL;
                else if (s2_zero) state_q <= ST_DONE;
                else              state_q <= ST_DIV;
            end
        end
    end

    assign busy = step;
    assign done = done_q;
    assign we   = done_q;
    assign op0  = op0_q;
    assign D    = D_q;

endmodule
